exe_div_unit: RTL and testbench
===============================

# exe_div_unit

Iterative radix-2 integer divider for the execute stage, implementing the RISC-V M-extension ops DIV, DIVU, REM and REMU plus their 32-bit W variants. It consumes the operands and decoded op presented by the RR/EXE pipeline latch. It raises STALL to freeze that latch for the duration of the division and returns a single-cycle RESULT_VALID pulse with the 64-bit result. FLUSH aborts an in-flight operation.

## Interface
- DATA_WIDTH, 64, operand/result width; W variants operate on the low DATA_WIDTH/2 bits.
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-low.
- FLUSH  in  1  kill in-flight op; no accept this cycle.
- REQ_VALID  in  1  latch holds a valid divide op.
- OP  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- OP_W  in  1  word variant (DIVW/DIVUW/REMW/REMUW).
- SRC1  in  DATA_WIDTH  dividend.
- SRC2  in  DATA_WIDTH  divisor.
- STALL  out  1  combinational; holds RR/EXE latch (drives its lock).
- RESULT_VALID  out  1  registered; one-cycle result strobe.
- RESULT  out  DATA_WIDTH  registered result; holds value until the next RESULT_VALID.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: if REQ_VALID && !FLUSH, the unit accepts the request and registers the prepared operands, OP and OP_W.
  - Signed ops (OP[0]=0) take absolute values and record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - W ops first sign-extend (signed) or zero-extend (unsigned) the low 32 bits.
  - If the op is a special case, go to DONE with the special result preloaded. Otherwise go to CALC with count=0 and iteration limit N = DATA_WIDTH (or DATA_WIDTH/2 for W).
- Special cases, evaluated on extended operands at the operation width:
  - Divisor == 0: quotient = all ones, remainder = dividend.
  - Signed, dividend == most negative, divisor == -1: quotient = dividend, remainder = 0.
- CALC: one restoring step per cycle.
  - Shift {rem, quot} left 1, trial-subtract the divisor.
  - If non-negative, keep the difference and set quot[0] = 1.
  - count increments each step; after step N-1, go to DONE.
- DONE: RESULT_VALID=1 for exactly one cycle.
  - RESULT = quotient (OP[1]=0) or remainder (OP[1]=1), negated if the recorded sign is set (signed ops only).
  - For W ops, bits [63:32] replicate bit 31 of the 32-bit result, for all four ops.
  - Next state is IDLE unconditionally. REQ_VALID is ignored in DONE because it is still the old instruction.
- STALL = RST && !FLUSH && ((state==IDLE && REQ_VALID) || state==CALC). STALL is low in DONE so the latch advances on the RESULT_VALID cycle.
- REQ_VALID, OP and operand changes during CALC are ignored; the registered copies are used.

## Timing
- Reset (RST=0 at a CLK edge): state=IDLE, count=0, RESULT=0, RESULT_VALID=0. STALL is forced 0 while RST=0.
- Accept edge = cycle 0.
- RESULT_VALID latency:
  - 64-bit normal: cycle N+1 = 65.
  - W normal: cycle 33.
  - Special cases: cycle 1.
- STALL stays high from the accept cycle through the last CALC cycle: 65 cycles for 64-bit, 33 for W, 1 for special cases.
- FLUSH in any state: next state IDLE, count=0, RESULT_VALID=0 next cycle, RESULT unchanged. A FLUSH in the DONE cycle does not suppress that cycle's pulse, which is already registered.
- FLUSH and REQ_VALID together in IDLE: nothing is accepted and STALL=0.
- Back-to-back operations: a new REQ_VALID is accepted in the first IDLE cycle after DONE (earliest cycle N+2).
- RST low mid-CALC: the unit returns to IDLE on that edge and no result is produced.

## Test plan
- DIVU 100/7, 64-bit, accept at cycle 0 -> STALL high cycles 0-64; RESULT_VALID at cycle 65 with RESULT=14. Repeat with REMU -> RESULT=2.
- DIV SRC1=-7 (0xFFFF_FFFF_FFFF_FFF9), SRC2=2 -> RESULT=0xFFFF_FFFF_FFFF_FFFD. With REM -> RESULT=0xFFFF_FFFF_FFFF_FFFF.
- Divide by zero:
  - DIVU 5/0 -> RESULT=0xFFFF_FFFF_FFFF_FFFF with RESULT_VALID at cycle 1.
  - REMU 5/0 -> RESULT=5.
- Signed overflow:
  - DIV 0x8000_0000_0000_0000 / -1 -> RESULT=0x8000_0000_0000_0000 at cycle 1.
  - REM -> RESULT=0.
  - DIVW 0x0000_0000_8000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> RESULT=0xFFFF_FFFF_8000_0000.
- DIVUW SRC1=0x1234_5678_F000_0000, SRC2=0x10 -> RESULT_VALID at cycle 33 with RESULT=0x0000_0000_0F00_0000.
- FLUSH and reset handling:
  - FLUSH at cycle 10 of a 64-bit DIVU -> STALL low at cycle 10, no RESULT_VALID; a new DIVU 9/3 accepted at cycle 11 gives RESULT=3 at cycle 76.
  - RST=0 at cycle 20 mid-CALC -> RESULT=0, RESULT_VALID=0, state IDLE.

Source files
------------

// File: rtl/exe_div_unit.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU and W variants.
// Holds the RR/EXE latch via STALL while iterating; emits a one-cycle RESULT_VALID.
module exe_div_unit #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FLUSH,
  input  logic                  REQ_VALID,
  input  logic [1:0]            OP,
  input  logic                  OP_W,
  input  logic [DATA_WIDTH-1:0] SRC1,
  input  logic [DATA_WIDTH-1:0] SRC2,
  output logic                  STALL,
  output logic                  RESULT_VALID,
  output logic [DATA_WIDTH-1:0] RESULT
);
  localparam int DW = DATA_WIDTH;
  localparam int HW = DATA_WIDTH / 2;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_D = CW'(DW - 1);
  localparam logic [CW-1:0] LAST_W = CW'(HW - 1);
  localparam logic [DW-1:0] MIN_D  = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] MIN_W  = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   rem_q, rem_d, quot_q, quot_d, dvs_q, dvs_d, res_q, res_d;
  logic [1:0]      op_q, op_d;
  logic            w_q, w_d, sgq_q, sgq_d, sgr_q, sgr_d, vld_q, vld_d;

  logic [DW-1:0]   ext1, ext2, abs1, abs2, spec_raw, rem_n, quot_n, fin_raw, fin;
  logic            sgn, s1, s2, div0, ovf, ge, fin_neg;
  logic [DW:0]     sh, diff;

  // W results always sign-extend bit HW-1, even for the unsigned ops
  function automatic logic [DW-1:0] wfix(input logic [DW-1:0] x, input logic w);
    return w ? {{HW{x[HW-1]}}, x[HW-1:0]} : x;
  endfunction

  always_comb begin
    sgn  = ~OP[0];
    ext1 = OP_W ? (OP[0] ? {{HW{1'b0}}, SRC1[HW-1:0]} : {{HW{SRC1[HW-1]}}, SRC1[HW-1:0]}) : SRC1;
    ext2 = OP_W ? (OP[0] ? {{HW{1'b0}}, SRC2[HW-1:0]} : {{HW{SRC2[HW-1]}}, SRC2[HW-1:0]}) : SRC2;
    s1   = sgn & ext1[DW-1];
    s2   = sgn & ext2[DW-1];
    abs1 = s1 ? -ext1 : ext1;
    abs2 = s2 ? -ext2 : ext2;
    div0 = (ext2 == '0);
    ovf  = sgn && (ext1 == (OP_W ? MIN_W : MIN_D)) && (ext2 == '1);
    if (div0) spec_raw = OP[1] ? ext1 : '1;
    else      spec_raw = OP[1] ? '0   : ext1;

    sh      = {rem_q, quot_q[DW-1]};
    diff    = sh - {1'b0, dvs_q};
    ge      = ~diff[DW];
    rem_n   = ge ? diff[DW-1:0] : sh[DW-1:0];
    quot_n  = {quot_q[DW-2:0], ge};
    fin_raw = op_q[1] ? rem_n : quot_n;
    fin_neg = ~op_q[0] & (op_q[1] ? sgr_q : sgq_q);
    fin     = fin_neg ? -fin_raw : fin_raw;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    op_d    = op_q;
    w_d     = w_q;
    sgq_d   = sgq_q;
    sgr_d   = sgr_q;
    vld_d   = 1'b0;
    case (state_q)
      IDLE: if (REQ_VALID && !FLUSH) begin
        op_d  = OP;
        w_d   = OP_W;
        sgq_d = s1 ^ s2;
        sgr_d = s1;
        dvs_d = abs2;
        rem_d = '0;
        // W dividend sits in the upper half so HW shifts consume it
        quot_d = OP_W ? {abs1[HW-1:0], {HW{1'b0}}} : abs1;
        cnt_d  = '0;
        if (div0 || ovf) begin
          res_d   = wfix(spec_raw, OP_W);
          vld_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = CALC;
        end
      end
      CALC: begin
        rem_d  = rem_n;
        quot_d = quot_n;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == (w_q ? LAST_W : LAST_D)) begin
          res_d   = wfix(fin, w_q);
          vld_d   = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (FLUSH) begin
      state_d = IDLE;
      cnt_d   = '0;
      vld_d   = 1'b0;
      res_d   = res_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      vld_q   <= 1'b0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
      op_q    <= '0;
      w_q     <= 1'b0;
      sgq_q   <= 1'b0;
      sgr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      op_q    <= op_d;
      w_q     <= w_d;
      sgq_q   <= sgq_d;
      sgr_q   <= sgr_d;
    end
  end

  assign STALL        = RST && !FLUSH && ((state_q == IDLE && REQ_VALID) || state_q == CALC);
  assign RESULT_VALID = vld_q;
  assign RESULT       = res_q;
endmodule

// File: tb/tb_exe_div_unit.sv
// Directed bench for exe_div_unit: latency, STALL window, results, flush and reset.
module tb_exe_div_unit;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        FLUSH = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic [1:0]  OP = 2'b00;
  logic        OP_W = 1'b0;
  logic [63:0] SRC1 = '0;
  logic [63:0] SRC2 = '0;
  logic        STALL;
  logic        RESULT_VALID;
  logic [63:0] RESULT;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  exe_div_unit #(.DATA_WIDTH(64)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .REQ_VALID(REQ_VALID),
    .OP(OP), .OP_W(OP_W), .SRC1(SRC1), .SRC2(SRC2),
    .STALL(STALL), .RESULT_VALID(RESULT_VALID), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  // Called 1ns after a rising edge; that cycle is the accept cycle (cycle 0).
  task automatic do_op(input string tag, input logic [1:0] op, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int lat);
    int seen = -1;
    int stalls = 0;
    logic stall_at_pulse = 1'b1;
    OP = op; OP_W = w; SRC1 = a; SRC2 = b; REQ_VALID = 1'b1;
    #1;
    for (int c = 0; c <= lat + 4 && seen < 0; c++) begin
      if (c > 0) step();
      if (RESULT_VALID) begin
        seen = c;
        stall_at_pulse = STALL;
      end else if (STALL) begin
        stalls++;
      end
    end
    chk({tag, " latency"}, 64'(seen), 64'(lat));
    chk({tag, " stall_cycles"}, 64'(stalls), 64'(lat));
    chk({tag, " result"}, RESULT, exp);
    chk({tag, " stall_in_done"}, {63'b0, stall_at_pulse}, 64'd0);
    REQ_VALID = 1'b0;
    step();
    chk({tag, " pulse_width"}, {63'b0, RESULT_VALID}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bad_vld;
    REQ_VALID = 1'b1;
    OP = DIVU; SRC1 = 64'd100; SRC2 = 64'd7;
    repeat (3) step();
    chk("reset_stall", {63'b0, STALL}, 64'd0);
    chk("reset_valid", {63'b0, RESULT_VALID}, 64'd0);
    chk("reset_result", RESULT, 64'd0);
    REQ_VALID = 1'b0;
    RST = 1'b1;
    step();

    do_op("divu_100_7", DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    do_op("remu_100_7", REMU, 1'b0, 64'd100, 64'd7, 64'd2, 65);
    do_op("div_m7_2", DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    do_op("rem_m7_2", REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    do_op("divu_by0", DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    do_op("remu_by0", REMU, 1'b0, 64'd5, 64'd0, 64'd5, 1);
    do_op("div_ovf", DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
    do_op("rem_ovf", REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    do_op("divw_ovf", DIV, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    do_op("divuw", DIVU, 1'b1, 64'h1234_5678_F000_0000, 64'h10, 64'h0000_0000_0F00_0000, 33);
    do_op("remw_m7_2", REM, 1'b1, 64'hABCD_0000_FFFF_FFF9, 64'h5555_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    do_op("divw_100_5", DIV, 1'b1, 64'hDEAD_BEEF_0000_0064, 64'h0000_0001_0000_0005, 64'd20, 33);

    // Flush at cycle 10 of a 64-bit op, then a fresh op on cycle 11
    OP = DIVU; OP_W = 1'b0; SRC1 = 64'd100; SRC2 = 64'd7; REQ_VALID = 1'b1;
    repeat (10) step();
    FLUSH = 1'b1;
    #1;
    chk("flush_stall", {63'b0, STALL}, 64'd0);
    step();
    FLUSH = 1'b0;
    chk("flush_no_valid", {63'b0, RESULT_VALID}, 64'd0);
    chk("flush_result_held", RESULT, 64'd20);
    do_op("after_flush_9_3", DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 65);

    // Reset in the middle of CALC
    OP = DIVU; SRC1 = 64'd1000; SRC2 = 64'd3; REQ_VALID = 1'b1;
    repeat (20) step();
    RST = 1'b0;
    #1;
    chk("rst_mid_stall", {63'b0, STALL}, 64'd0);
    step();
    chk("rst_mid_valid", {63'b0, RESULT_VALID}, 64'd0);
    chk("rst_mid_result", RESULT, 64'd0);
    REQ_VALID = 1'b0;
    RST = 1'b1;
    step();
    chk("rst_mid_idle", {63'b0, STALL}, 64'd0);
    bad_vld = 0;
    for (int i = 0; i < 70; i++) begin
      step();
      if (RESULT_VALID) bad_vld++;
    end
    chk("rst_mid_no_result", 64'(bad_vld), 64'd0);
    do_op("after_rst_by0", REMU, 1'b0, 64'd77, 64'd0, 64'd77, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
